// File: rtl/can_pkg.sv
// Shared types and constants for the CAN transmit bit stuffer.
package can_pkg;

  // Stuffer sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2,
    DONE  = 2'd3
  } can_stuff_state_t;

  // Idle bus level
  localparam logic CAN_RECESSIVE = 1'b1;

  // Standard CAN stuffing run length
  localparam int unsigned CAN_STUFF_RUN_DEFAULT = 5;

  // Width of a counter able to hold the worst-case stuff-bit count of one field
  function automatic int unsigned can_stuff_cnt_width(input int unsigned max_bits,
                                                      input int unsigned stuff_run);
    return $clog2(max_bits / (stuff_run - 1) + 2);
  endfunction

endpackage

// File: rtl/can_run_tracker.sv
// Tracks the last committed bus bit and the length of the current run of
// identical bits. Shared by the stuffer and the future destuffer.
module can_run_tracker
  import can_pkg::*;
#(
  parameter int unsigned STUFF_RUN = CAN_STUFF_RUN_DEFAULT
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear,
  input  logic commit,
  input  logic bit_val,
  output logic last_bit,
  output logic run_hit,
  output logic run_hit_next_c
);

  localparam int unsigned       RUN_W      = $clog2(STUFF_RUN + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX    = '1;
  localparam logic [RUN_W-1:0]  RUN_TARGET = RUN_W'(STUFF_RUN);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_next;

  // Run length that results if bit_val is committed now (saturating)
  always_comb begin
    run_next = RUN_W'(1);
    if (bit_val == last_bit) begin
      run_next = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end
  end

  // Run counter and last-bit register; clear wins over commit
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      run_q    <= '0;
      last_bit <= CAN_RECESSIVE;
    end else if (clear) begin
      run_q    <= '0;
      last_bit <= CAN_RECESSIVE;
    end else if (commit) begin
      run_q    <= run_next;
      last_bit <= bit_val;
    end
  end

  assign run_hit        = (run_q == RUN_TARGET);
  assign run_hit_next_c = (run_next == RUN_TARGET);

endmodule

// File: rtl/can_bit_stuffer_stream.sv
// CAN transmit bit stuffer: serialises a variable-length MSB-first field one
// bit per bit_tick_i and inserts a complement bit after every STUFF_RUN
// identical bits. Stuff bits start the next run.
module can_bit_stuffer_stream
  import can_pkg::*;
#(
  parameter int unsigned MAX_BITS       = 66,
  parameter int unsigned STUFF_RUN      = CAN_STUFF_RUN_DEFAULT,
  parameter int unsigned TRAILING_STUFF = 1
) (
  input  logic                                                 clock_i,
  input  logic                                                 reset_i,
  input  logic [MAX_BITS-1:0]                                  data_i,
  input  logic [$clog2(MAX_BITS+1)-1:0]                        len_i,
  input  logic                                                 start_i,
  input  logic                                                 bit_tick_i,
  input  logic                                                 abort_i,
  output logic                                                 serial_o,
  output logic                                                 stuff_bit_o,
  output logic                                                 busy_o,
  output logic                                                 done_o,
  output logic [can_stuff_cnt_width(MAX_BITS, STUFF_RUN)-1:0]  stuff_count_o
);

  localparam int unsigned LEN_W = $clog2(MAX_BITS + 1);
  localparam int unsigned CNT_W = can_stuff_cnt_width(MAX_BITS, STUFF_RUN);

  can_stuff_state_t    state_q;
  can_stuff_state_t    state_d;
  logic [MAX_BITS-1:0] shreg_q;
  logic [MAX_BITS-1:0] shreg_d;
  logic [LEN_W-1:0]    rem_q;
  logic [LEN_W-1:0]    rem_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                serial_d;
  logic                stuff_d;
  logic                busy_d;
  logic                done_d;

  logic                len_ok_c;
  logic [MAX_BITS-1:0] shreg_load_c;
  logic [MAX_BITS-1:0] shreg_shift_c;
  logic [LEN_W-1:0]    rem_dec_c;
  logic                cur_bit_c;

  logic                trk_clear;
  logic                trk_commit;
  logic                trk_bit;
  logic                trk_last;
  logic                trk_hit_next;
  // Registered run_hit is only needed by the destuffer; decisions here use the lookahead
  logic                trk_run_hit_unused;

  // Field preprocessing: left-align the field so its first bit sits at the MSB
  assign len_ok_c      = (len_i != '0) && (len_i <= LEN_W'(MAX_BITS));
  assign shreg_load_c  = data_i << (LEN_W'(MAX_BITS) - len_i);
  assign shreg_shift_c = {shreg_q[MAX_BITS-2:0], 1'b0};
  assign rem_dec_c     = rem_q - LEN_W'(1);
  assign cur_bit_c     = shreg_q[MAX_BITS-1];

  can_run_tracker #(
    .STUFF_RUN (STUFF_RUN)
  ) u_run_tracker (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .clear          (trk_clear),
    .commit         (trk_commit),
    .bit_val        (trk_bit),
    .last_bit       (trk_last),
    .run_hit        (trk_run_hit_unused),
    .run_hit_next_c (trk_hit_next)
  );

  // Next-state and next-output logic; outputs hold between ticks by default
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    cnt_d      = stuff_count_o;
    serial_d   = serial_o;
    stuff_d    = stuff_bit_o;
    busy_d     = busy_o;
    done_d     = 1'b0;
    trk_clear  = 1'b0;
    trk_commit = 1'b0;
    trk_bit    = cur_bit_c;

    if (abort_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      serial_d = CAN_RECESSIVE;
      stuff_d  = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          serial_d = CAN_RECESSIVE;
          stuff_d  = 1'b0;
          busy_d   = 1'b0;
          if (start_i && len_ok_c) begin
            state_d   = SEND;
            shreg_d   = shreg_load_c;
            rem_d     = len_i;
            cnt_d     = '0;
            trk_clear = 1'b1;
            serial_d  = shreg_load_c[MAX_BITS-1];
            busy_d    = 1'b1;
          end
        end

        SEND: begin
          if (bit_tick_i) begin
            trk_commit = 1'b1;
            trk_bit    = cur_bit_c;
            shreg_d    = shreg_shift_c;
            rem_d      = rem_dec_c;
            if (trk_hit_next && ((rem_dec_c != '0) || (TRAILING_STUFF != 0))) begin
              state_d  = STUFF;
              serial_d = ~cur_bit_c;
              stuff_d  = 1'b1;
            end else if (rem_dec_c == '0) begin
              state_d  = DONE;
              serial_d = CAN_RECESSIVE;
              stuff_d  = 1'b0;
              done_d   = 1'b1;
            end else begin
              serial_d = shreg_shift_c[MAX_BITS-1];
              stuff_d  = 1'b0;
            end
          end
        end

        STUFF: begin
          if (bit_tick_i) begin
            trk_commit = 1'b1;
            trk_bit    = ~trk_last;
            cnt_d      = stuff_count_o + CNT_W'(1);
            stuff_d    = 1'b0;
            if (rem_q == '0) begin
              state_d  = DONE;
              serial_d = CAN_RECESSIVE;
              done_d   = 1'b1;
            end else begin
              state_d  = SEND;
              serial_d = cur_bit_c;
            end
          end
        end

        DONE: begin
          state_d  = IDLE;
          serial_d = CAN_RECESSIVE;
          stuff_d  = 1'b0;
          busy_d   = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          serial_d = CAN_RECESSIVE;
          stuff_d  = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      rem_q         <= '0;
      serial_o      <= CAN_RECESSIVE;
      stuff_bit_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      stuff_count_o <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      rem_q         <= rem_d;
      serial_o      <= serial_d;
      stuff_bit_o   <= stuff_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      stuff_count_o <= cnt_d;
    end
  end

endmodule

// File: tb/tb_can_bit_stuffer_stream.sv
// Bench for can_bit_stuffer_stream: two instances (trailing stuff on/off)
// share all inputs; each is compared cycle by cycle against an expected
// symbol stream from a table or from a rule-level stuffing model.
module tb_can_bit_stuffer_stream;

  typedef struct {
    bit b;
    bit s;
  } sym_t;

  typedef struct {
    string       name;
    logic [65:0] data;
    int          len;
    string       seq_t;
    string       seq_n;
    int          cnt_t;
    int          cnt_n;
    int          gmin;
    int          gmax;
    int          poke;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [65:0] data_i = '0;
  logic [6:0]  len_i = '0;
  logic        start_i = 1'b0;
  logic        bit_tick_i = 1'b0;
  logic        abort_i = 1'b0;

  logic       ser_t, stf_t, busy_t, done_t;
  logic [4:0] cnt_t;
  logic       ser_n, stf_n, busy_n, done_n;
  logic [4:0] cnt_n;

  int checks = 0;
  int errors = 0;

  sym_t exp_t[$];
  sym_t exp_n[$];

  always #5 clk = ~clk;

  can_bit_stuffer_stream #(.MAX_BITS(66), .STUFF_RUN(5), .TRAILING_STUFF(1)) dut_t (
    .clock_i(clk), .reset_i(reset_i), .data_i(data_i), .len_i(len_i),
    .start_i(start_i), .bit_tick_i(bit_tick_i), .abort_i(abort_i),
    .serial_o(ser_t), .stuff_bit_o(stf_t), .busy_o(busy_t), .done_o(done_t),
    .stuff_count_o(cnt_t)
  );

  can_bit_stuffer_stream #(.MAX_BITS(66), .STUFF_RUN(5), .TRAILING_STUFF(0)) dut_n (
    .clock_i(clk), .reset_i(reset_i), .data_i(data_i), .len_i(len_i),
    .start_i(start_i), .bit_tick_i(bit_tick_i), .abort_i(abort_i),
    .serial_o(ser_n), .stuff_bit_o(stf_n), .busy_o(busy_n), .done_o(done_n),
    .stuff_count_o(cnt_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string what, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", what, got, want);
    end
  endtask

  // Behavioural stuffing rule: after STUFF_RUN equal bits add the complement,
  // which itself starts a new run; at the very end only if trailing is enabled.
  task automatic model_into(input int d, input logic [65:0] dat, input int len, input bit trail);
    int run = 0;
    bit last = 1'b0;
    sym_t sy;
    if (d == 0) exp_t.delete(); else exp_n.delete();
    for (int i = len - 1; i >= 0; i--) begin
      sy.b = dat[i];
      sy.s = 1'b0;
      if (d == 0) exp_t.push_back(sy); else exp_n.push_back(sy);
      if (run > 0 && sy.b == last) run++; else run = 1;
      last = sy.b;
      if (run == 5 && (i > 0 || trail)) begin
        sy.b = ~last;
        sy.s = 1'b1;
        if (d == 0) exp_t.push_back(sy); else exp_n.push_back(sy);
        last = sy.b;
        run = 1;
      end
    end
  endtask

  // '0'/'1' data bits, 'L'/'H' stuff bits of value 0/1
  task automatic parse_into(input int d, input string s);
    sym_t sy;
    if (d == 0) exp_t.delete(); else exp_n.delete();
    for (int i = 0; i < s.len(); i++) begin
      sy.b = (s[i] == "1" || s[i] == "H");
      sy.s = (s[i] == "L" || s[i] == "H");
      if (d == 0) exp_t.push_back(sy); else exp_n.push_back(sy);
    end
  endtask

  function automatic int exp_size(input int d);
    return (d == 0) ? exp_t.size() : exp_n.size();
  endfunction

  function automatic sym_t exp_at(input int d, input int i);
    return (d == 0) ? exp_t[i] : exp_n[i];
  endfunction

  function automatic int stuffs_before(input int d, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (exp_at(d, i).s) c++;
    return c;
  endfunction

  task automatic check_outputs(input int d, input int tk, input int post, input bit killed,
                               input bit rst, input string tag);
    int sz;
    int e_ser, e_stf, e_busy, e_done, e_cnt;
    sym_t sy;
    sz = exp_size(d);
    if (killed) begin
      e_ser = 1; e_stf = 0; e_busy = 0; e_done = 0;
      e_cnt = rst ? 0 : stuffs_before(d, tk);
    end else if (tk < sz) begin
      sy = exp_at(d, tk);
      e_ser = int'(sy.b); e_stf = int'(sy.s); e_busy = 1; e_done = 0;
      e_cnt = stuffs_before(d, tk);
    end else if (post == 1) begin
      e_ser = 1; e_stf = 0; e_busy = 1; e_done = 1; e_cnt = stuffs_before(d, sz);
    end else begin
      e_ser = 1; e_stf = 0; e_busy = 0; e_done = 0; e_cnt = stuffs_before(d, sz);
    end
    chk($sformatf("%s d%0d serial", tag, d), int'(d ? ser_n : ser_t), e_ser);
    chk($sformatf("%s d%0d stuff_bit", tag, d), int'(d ? stf_n : stf_t), e_stf);
    chk($sformatf("%s d%0d busy", tag, d), int'(d ? busy_n : busy_t), e_busy);
    chk($sformatf("%s d%0d done", tag, d), int'(d ? done_n : done_t), e_done);
    chk($sformatf("%s d%0d stuff_count", tag, d), int'(d ? cnt_n : cnt_t), e_cnt);
  endtask

  // Starts one transfer and follows it cycle by cycle until both instances
  // are idle again, or until an injected abort/reset has settled.
  task automatic run_case(input logic [65:0] dat, input int len, input int gmin, input int gmax,
                          input int abort_at, input int reset_at, input int poke, input string nm);
    int  tk[2];
    int  post[2];
    bit  killed = 1'b0;
    bit  rst = 1'b0;
    int  kill_cycles = 0;
    bit  finished = 1'b0;
    int  cd;
    int  cyc = 0;
    bit  tick, ab, rs;
    tk[0] = 0; tk[1] = 0; post[0] = 0; post[1] = 0;
    data_i = dat;
    len_i = 7'(len);
    start_i = 1'b1;
    bit_tick_i = 1'($urandom_range(1, 0));
    step();
    start_i = 1'b0;
    bit_tick_i = 1'b0;
    cd = int'($urandom_range(gmax, gmin));
    while (!finished && cyc < 3000) begin
      for (int d = 0; d < 2; d++)
        check_outputs(d, tk[d], post[d], killed, rst, $sformatf("%s c%0d", nm, cyc));
      if (killed) begin
        kill_cycles++;
        if (kill_cycles >= 3) finished = 1'b1;
      end else if (post[0] >= 2 && post[1] >= 2) begin
        finished = 1'b1;
      end
      if (!finished) begin
        tick = 1'b0; ab = 1'b0; rs = 1'b0;
        cd--;
        if (cd <= 0) begin
          tick = 1'b1;
          cd = int'($urandom_range(gmax, gmin));
        end
        if (!killed && abort_at >= 0 && tk[0] == abort_at) begin ab = 1'b1; tick = 1'b1; end
        if (!killed && reset_at >= 0 && tk[0] == reset_at) begin rs = 1'b1; tick = 1'b1; end
        if (cyc == poke) begin
          start_i = 1'b1;
          data_i = {$urandom, $urandom, 2'b01};
          len_i = 7'd8;
        end
        bit_tick_i = tick;
        abort_i = ab;
        reset_i = rs;
        step();
        bit_tick_i = 1'b0; abort_i = 1'b0; reset_i = 1'b0; start_i = 1'b0;
        if (ab || rs) begin
          killed = 1'b1;
          rst = rs;
        end else if (!killed) begin
          for (int d = 0; d < 2; d++) begin
            if (post[d] > 0) post[d]++;
            else if (tick && tk[d] < exp_size(d)) begin
              tk[d]++;
              if (tk[d] == exp_size(d)) post[d] = 1;
            end
          end
        end
        cyc++;
      end
    end
    if (!finished) chk($sformatf("%s timeout", nm), 0, 1);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{"s1_11111000", 66'b11111000, 8, "11111L000", "11111L000", 1, 1, 3, 3, -1};
    tbl[1] = '{"s2_zeros", 66'd0, 10, "00000H00000H", "00000H00000", 2, 1, 3, 3, -1};
    tbl[2] = '{"s3_stuff_in_run", 66'b0000011110, 10, "00000H1111L0", "00000H1111L0", 2, 2, 3, 3, -1};
    tbl[3] = '{"len1", 66'd1, 1, "1", "1", 0, 0, 3, 3, -1};
    tbl[4] = '{"run_on_last", 66'b11111, 5, "11111L", "11111", 1, 0, 3, 3, -1};
    tbl[5] = '{"run_then_one", 66'b111110, 6, "11111L0", "11111L0", 1, 1, 1, 1, -1};
    tbl[6] = '{"alt66_gaps", {2'b10, 64'hAAAA_AAAA_AAAA_AAAA}, 66, "", "", 0, 0, 1, 7, 30};
    tbl[7] = '{"ones66", {66{1'b1}}, 66, "", "", 13, 13, 2, 2, -1};

    // Reset values, sampled while reset is still held
    step();
    step();
    exp_t.delete();
    exp_n.delete();
    for (int d = 0; d < 2; d++) check_outputs(d, 0, 0, 1'b1, 1'b1, "reset");
    reset_i = 1'b0;
    step();

    // Directed table
    for (int r = 0; r < 8; r++) begin
      if (tbl[r].seq_t.len() > 0) parse_into(0, tbl[r].seq_t);
      else model_into(0, tbl[r].data, tbl[r].len, 1'b1);
      if (tbl[r].seq_n.len() > 0) parse_into(1, tbl[r].seq_n);
      else model_into(1, tbl[r].data, tbl[r].len, 1'b0);
      run_case(tbl[r].data, tbl[r].len, tbl[r].gmin, tbl[r].gmax, -1, -1, tbl[r].poke, tbl[r].name);
      chk({tbl[r].name, " final_count t"}, int'(cnt_t), tbl[r].cnt_t);
      chk({tbl[r].name, " final_count n"}, int'(cnt_n), tbl[r].cnt_n);
      chk({tbl[r].name, " ticks t"}, exp_t.size(), tbl[r].len + tbl[r].cnt_t);
    end

    // Abort after the fourth tick of scenario 1 (a tick in the same cycle loses)
    parse_into(0, "11111L000");
    parse_into(1, "11111L000");
    run_case(66'b11111000, 8, 3, 3, 4, -1, -1, "abort");

    // Illegal lengths are ignored in IDLE
    data_i = 66'h3;
    len_i = 7'd0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk("len0 busy", int'(busy_t), 0);
    chk("len0 serial", int'(ser_t), 1);
    chk("len0 count", int'(cnt_t), 0);
    len_i = 7'd67;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("len67 busy", int'(busy_t), 0);
    chk("len67 busy n", int'(busy_n), 0);
    step();
    chk("len67 done", int'(done_t), 0);

    // Reset while scenario 2 is emitting its first stuff bit, then a clean rerun
    parse_into(0, "00000H00000H");
    parse_into(1, "00000H00000");
    run_case(66'd0, 10, 3, 3, -1, 5, -1, "reset_mid");
    parse_into(0, "11111L000");
    parse_into(1, "11111L000");
    run_case(66'b11111000, 8, 3, 3, -1, -1, -1, "after_reset");
    chk("after_reset count", int'(cnt_t), 1);

    // Random fields with long runs, checked against the rule model
    for (int n = 0; n < 30; n++) begin
      logic [65:0] dat;
      int          len;
      bit          b;
      b = 1'($urandom_range(1, 0));
      for (int i = 0; i < 66; i++) begin
        if ($urandom_range(3, 0) == 0) b = ~b;
        dat[i] = b;
      end
      len = int'($urandom_range(66, 1));
      model_into(0, dat, len, 1'b1);
      model_into(1, dat, len, 1'b0);
      run_case(dat, len, 1, 4, -1, -1, -1, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/can_bit_stuffer_stream.md
# can_bit_stuffer_stream

Parametrised CAN transmit bit stuffer. It serialises a variable-length, MSB-first bit field and inserts a complement stuff bit after every STUFF_RUN consecutive identical transmitted bits. Stuff bits count toward the following run. The transmitter's bit-timing logic paces it one bit per `bit_tick_i`. It sits between the frame assembler (SOF through CRC field) and the TX bit-timing/driver stage, and replaces the fixed 66-bit, free-running stuffer.

## Interface
Parameters:
- `MAX_BITS`, 66: maximum field length in bits.
- `STUFF_RUN`, 5: run length that triggers a stuff bit; legal range 2..15.
- `TRAILING_STUFF`, 1: if 1, a stuff bit is emitted when the run completes on the final data bit.

Ports:
- `clock_i` in 1: single clock; all state updates on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `data_i` in MAX_BITS: field; `data_i[len_i-1]` is sent first, `data_i[0]` last.
- `len_i` in $clog2(MAX_BITS+1): field length; sampled with `start_i`.
- `start_i` in 1: load request; honoured only in IDLE.
- `bit_tick_i` in 1: advance to the next output bit.
- `abort_i` in 1: cancel the transfer (error/arbitration loss).
- `serial_o` out 1: current TX bit; recessive 1 when not busy.
- `stuff_bit_o` out 1: current `serial_o` is a stuff bit.
- `busy_o` out 1: a transfer is in progress.
- `done_o` out 1: one-cycle completion pulse.
- `stuff_count_o` out $clog2(MAX_BITS/(STUFF_RUN-1)+2): stuff bits inserted in the last or current transfer.

## Operation
- State machine IDLE → SEND ↔ STUFF → DONE → IDLE.
- **IDLE**
  - On `start_i` with 1 ≤ `len_i` ≤ MAX_BITS: load `data_i` into the shift register and `len_i` into the remaining-bit counter, clear the run counter and `stuff_count_o`, then go to SEND.
  - `len_i` of 0 or above MAX_BITS: the start is ignored and the block stays in IDLE.
- **SEND**
  - `serial_o` = shift register MSB.
  - On `bit_tick_i`, commit this bit to the run tracker: if it equals the last committed bit, run = run+1; otherwise run = 1. Then shift and decrement the remaining count.
  - If the updated run == STUFF_RUN and (bits remain or TRAILING_STUFF=1), go to STUFF.
  - Else, if no bits remain, go to DONE.
  - Else, stay in SEND.
- **STUFF**
  - `serial_o` = ~last committed bit; `stuff_bit_o` = 1.
  - On `bit_tick_i`: commit it (run = 1, last = stuff value) and increment `stuff_count_o`. Go to DONE if no bits remain, otherwise to SEND.
- **DONE**
  - `done_o` = 1 for one cycle; `serial_o` = 1; then go to IDLE.
- **`abort_i`** (any non-IDLE state): go to IDLE on the next edge. No `done_o`; `stuff_count_o` holds its value.
- **`start_i` while busy**: ignored. A `start_i` in the DONE cycle is also ignored.
- **Gaps between ticks**: `serial_o` and `stuff_bit_o` hold their values for any number of cycles between ticks.

## Timing
- Reset values: IDLE, `serial_o`=1, `stuff_bit_o`=0, `busy_o`=0, `done_o`=0, `stuff_count_o`=0, run=0.
  - Reset takes priority over `abort_i`, `start_i` and `bit_tick_i`, including mid-transfer.
- Start latency:
  - Edge k samples `start_i`.
  - From cycle k+1, `busy_o`=1 and `serial_o` = first data bit.
  - A `bit_tick_i` in cycle k is not applied.
- Bit advance: each tick cycle is followed by the next bit on `serial_o` in the following cycle; there is no lookahead.
- Completion: the cycle after the final bit's tick is DONE (`done_o`=1, `busy_o`=1). IDLE (`busy_o`=0) follows one cycle later.
- `abort_i` and `bit_tick_i` in the same cycle: abort wins.
- Total ticks per transfer = `len_i` + final `stuff_count_o`.

## Structure
- `can_pkg` holds:
  - `can_stuff_state_t` (IDLE, SEND, STUFF, DONE);
  - `CAN_RECESSIVE` = 1'b1;
  - `CAN_STUFF_RUN_DEFAULT` = 5.
- One sub-module, `can_run_tracker`:
  - holds the last committed bit and a saturating run counter of width $clog2(STUFF_RUN+1);
  - inputs: commit strobe, bit value, clear;
  - output: `run_hit` (run == STUFF_RUN).
  - Reuse in the future destuffer.

## Test plan
All scenarios use MAX_BITS=66, STUFF_RUN=5, TRAILING_STUFF=1, and a tick every 3 cycles unless stated.
- `len_i`=8, data 8'b11111000 → serial 1,1,1,1,1,0s,0,0,0 (s = stuff bit, `stuff_bit_o`=1); 9 ticks; `stuff_count_o`=1; `done_o` 1 cycle after 9th tick.
- `len_i`=10, data all 0 → 0×5, 1s, 0×5, 1s (trailing); 12 ticks; `stuff_count_o`=2. Repeat with TRAILING_STUFF=0 → 11 ticks, count 1.
- `len_i`=10, data 10'b0000011110 → 0×5, 1s, 1,1,1,1, 0s, 0; the stuff bit counts toward the 1-run; `stuff_count_o`=2.
- `len_i`=66, alternating 1010… with random tick gaps (1–7 cycles) → 66 bits and 0 stuffs. `start_i` pulsed mid-transfer is ignored and the output is unchanged.
- `abort_i` after tick 4 of scenario 1 → `serial_o`=1 and `busy_o`=0 next cycle, no `done_o`, `stuff_count_o`=0. Then `start_i` with `len_i`=0 → stays IDLE.
- `reset_i` asserted in the STUFF state of scenario 2 → all outputs equal their reset values on the next cycle. A new start then runs scenario 1 correctly.
